// File: rtl/c7bexu_stall_pkg.sv
// Shared constants and helpers for the c7bexu execute-stage stall controller.
package c7bexu_stall_pkg;

    localparam logic STALL_MODE_EVT = 1'b0;
    localparam logic STALL_MODE_FIX = 1'b1;

    localparam int unsigned C7BEXU_STALL_NCH     = 4;
    localparam int unsigned C7BEXU_STALL_CNTW    = 4;
    localparam int unsigned C7BEXU_STALL_TMO_CYC = 64;

    // Wide enough for 16 channels of 16-bit lengths.
    localparam int unsigned LEN_VEC_W = 256;

    function automatic int unsigned ch_len_at(input logic [LEN_VEC_W-1:0] lens,
                                              input int unsigned          idx,
                                              input int unsigned          cntw);
        logic [LEN_VEC_W-1:0] sh;
        sh = lens >> (idx * cntw);
        return sh[31:0] & ((32'd1 << cntw) - 32'd1);
    endfunction

endpackage

// File: rtl/c7bexu_stall_chan.sv
// One stall channel: event-terminated (begin/end) or fixed-length (down-counter).
// Optional watchdog on event channels enabled by C7BEXU_STALL_TMO_EN.
module c7bexu_stall_chan
    import c7bexu_stall_pkg::*;
#(
    parameter logic        MODE    = STALL_MODE_EVT,
    parameter int unsigned LEN     = 2,
    parameter int unsigned CNTW    = C7BEXU_STALL_CNTW,
    parameter int unsigned TMO_CYC = C7BEXU_STALL_TMO_CYC
) (
    input  logic clk,
    input  logic resetn,
    input  logic bgn,
    input  logic fin,
    input  logic flush,
    output logic ifu,
    output logic mw,
    output logic busy,
    output logic tmo
);

    logic [63:0] unused_cfg;
    assign unused_cfg = {32'(TMO_CYC), 32'(LEN)};

    generate
        if (MODE == STALL_MODE_FIX) begin : g_fix
            logic [CNTW-1:0] cnt;
            logic            unused_fin;
            assign unused_fin = fin;

            // Flush beats a same-cycle begin; a begin while busy restarts the count.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt <= '0;
                end else if (flush) begin
                    cnt <= '0;
                end else if (bgn) begin
                    cnt <= CNTW'(LEN - 1);
                end else if (cnt != '0) begin
                    cnt <= cnt - CNTW'(1);
                end
            end

            assign busy = (cnt != '0);
            assign ifu  = bgn | busy;
            assign mw   = busy;
            assign tmo  = 1'b0;
        end else begin : g_evt
            logic q;
            logic q_next;
            logic hit;

`ifdef C7BEXU_STALL_TMO_EN
            localparam int unsigned WW = $clog2(TMO_CYC + 1);
            logic [WW-1:0] wcnt;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    wcnt <= '0;
                end else if (!q) begin
                    wcnt <= '0;
                end else if (!hit) begin
                    wcnt <= wcnt + WW'(1);
                end
            end

            assign hit = q && (wcnt == WW'(TMO_CYC));
`else
            assign hit = 1'b0;
`endif

            assign q_next = ~fin & ~flush & ~hit & (bgn | q);

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    q <= 1'b0;
                end else begin
                    q <= q_next;
                end
            end

            // A timed-out channel releases the pipeline in the same cycle it reports.
            assign ifu  = ~fin & (bgn | (q & ~hit));
            assign mw   = q & ~hit & ~fin;
            assign busy = q;
            assign tmo  = hit;
        end
    endgenerate

endmodule

// File: rtl/c7bexu_stall_ctl.sv
// Execute-stage stall controller: merges NCH stall channels into IFU stall and M/W hold.
// Optional per-channel watchdog enabled by defining C7BEXU_STALL_TMO_EN.
module c7bexu_stall_ctl
    import c7bexu_stall_pkg::*;
#(
    parameter int unsigned          NCH     = C7BEXU_STALL_NCH,
    parameter int unsigned          CNTW    = C7BEXU_STALL_CNTW,
    parameter logic [NCH-1:0]       CH_MODE = NCH'(4'b0010),
    parameter logic [NCH*CNTW-1:0]  CH_LEN  = {NCH{CNTW'(2)}},
    parameter int unsigned          TMO_CYC = C7BEXU_STALL_TMO_CYC
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [NCH-1:0] ch_bgn,
    input  logic [NCH-1:0] ch_end,
    input  logic           flush,
    output logic           stall_ifu,
    output logic           stall_reg_mw,
    output logic [NCH-1:0] ch_busy,
    output logic [NCH-1:0] tmo_err
);

    localparam logic [LEN_VEC_W-1:0] CH_LEN_EXT = LEN_VEC_W'(CH_LEN);

    logic [NCH-1:0] ifu_v;
    logic [NCH-1:0] mw_v;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            c7bexu_stall_chan #(
                .MODE    (CH_MODE[i]),
                .LEN     (ch_len_at(CH_LEN_EXT, i, CNTW)),
                .CNTW    (CNTW),
                .TMO_CYC (TMO_CYC)
            ) u_chan (
                .clk    (clk),
                .resetn (resetn),
                .bgn    (ch_bgn[i]),
                .fin    (ch_end[i]),
                .flush  (flush),
                .ifu    (ifu_v[i]),
                .mw     (mw_v[i]),
                .busy   (ch_busy[i]),
                .tmo    (tmo_err[i])
            );
        end
    endgenerate

    assign stall_ifu    = |ifu_v;
    assign stall_reg_mw = |mw_v;

endmodule

// File: tb/tb_c7bexu_stall_ctl.sv
// Directed self-checking bench for c7bexu_stall_ctl (default build, 4 channels, ch1 fixed L=2).
module tb_c7bexu_stall_ctl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] ch_bgn;
    logic [3:0] ch_end;
    logic       flush;
    logic       stall_ifu;
    logic       stall_reg_mw;
    logic [3:0] ch_busy;
    logic [3:0] tmo_err;

    int checks = 0;
    int errors = 0;

    c7bexu_stall_ctl dut (
        .clk          (clk),
        .resetn       (resetn),
        .ch_bgn       (ch_bgn),
        .ch_end       (ch_end),
        .flush        (flush),
        .stall_ifu    (stall_ifu),
        .stall_reg_mw (stall_reg_mw),
        .ch_busy      (ch_busy),
        .tmo_err      (tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ch_bgn = '0;
        ch_end = '0;
        flush  = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_ifu, stall_reg_mw, ch_busy, tmo_err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, need 0", {stall_ifu, stall_reg_mw, ch_busy, tmo_err});
        end
        resetn = 1'b1;
        adv();
        adv();
    endtask

    // ch0 event: bgn at 5, end at 9.
    task automatic test_event();
        for (int c = 0; c < 12; c++) begin
            ch_bgn = (c == 5) ? 4'b0001 : 4'b0000;
            ch_end = (c == 9) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            checks++;
            if (stall_ifu !== (c >= 5 && c <= 8)) begin
                errors++;
                $display("FAIL evt_ifu c%0d: got %b, need %b", c, stall_ifu, (c >= 5 && c <= 8));
            end
            checks++;
            if (stall_reg_mw !== (c >= 6 && c <= 8)) begin
                errors++;
                $display("FAIL evt_mw c%0d: got %b, need %b", c, stall_reg_mw, (c >= 6 && c <= 8));
            end
            checks++;
            if (ch_busy !== ((c >= 6 && c <= 9) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL evt_busy c%0d: got %b, need %b", c, ch_busy, (c >= 6 && c <= 9) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (tmo_err !== 4'b0000) begin
                errors++;
                $display("FAIL evt_tmo c%0d: got %b, need 0000", c, tmo_err);
            end
            adv();
        end
        ch_bgn = '0;
        ch_end = '0;
    endtask

    // ch1 fixed L=2: single begin at 3, or begins at 3 and 4 (reload).
    task automatic test_fixed(input bit reload);
        logic ifu_exp, mw_exp;
        for (int c = 0; c < 8; c++) begin
            ch_bgn = (c == 3 || (reload && c == 4)) ? 4'b0010 : 4'b0000;
            ch_end = 4'b0000;
            ifu_exp = reload ? (c >= 3 && c <= 5) : (c >= 3 && c <= 4);
            mw_exp  = reload ? (c >= 4 && c <= 5) : (c == 4);
            @(negedge clk);
            checks++;
            if (stall_ifu !== ifu_exp) begin
                errors++;
                $display("FAIL fix_ifu r%0d c%0d: got %b, need %b", reload, c, stall_ifu, ifu_exp);
            end
            checks++;
            if (stall_reg_mw !== mw_exp) begin
                errors++;
                $display("FAIL fix_mw r%0d c%0d: got %b, need %b", reload, c, stall_reg_mw, mw_exp);
            end
            checks++;
            if (ch_busy !== (mw_exp ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL fix_busy r%0d c%0d: got %b, need %b", reload, c, ch_busy, mw_exp ? 4'b0010 : 4'b0000);
            end
            adv();
        end
        ch_bgn = '0;
    endtask

    // ch0 bgn and end together at cycle 2: end wins.
    task automatic test_bgn_end_same();
        for (int c = 0; c < 6; c++) begin
            ch_bgn = (c == 2) ? 4'b0001 : 4'b0000;
            ch_end = (c == 2) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            checks++;
            if ({stall_ifu, stall_reg_mw, ch_busy} !== 6'b0) begin
                errors++;
                $display("FAIL same_cycle c%0d: got %b, need 000000", c, {stall_ifu, stall_reg_mw, ch_busy});
            end
            adv();
        end
        ch_bgn = '0;
        ch_end = '0;
    endtask

    // ch0 and ch1 bgn at 0, flush at 1; flush does not alter the flush-cycle stall.
    task automatic test_flush();
        logic [5:0] exp;
        for (int c = 0; c < 5; c++) begin
            ch_bgn = (c == 0) ? 4'b0011 : 4'b0000;
            ch_end = 4'b0000;
            flush  = (c == 1);
            case (c)
                0:       exp = {1'b1, 1'b0, 4'b0000};
                1:       exp = {1'b1, 1'b1, 4'b0011};
                default: exp = 6'b0;
            endcase
            @(negedge clk);
            checks++;
            if ({stall_ifu, stall_reg_mw, ch_busy} !== exp) begin
                errors++;
                $display("FAIL flush c%0d: got %b, need %b", c, {stall_ifu, stall_reg_mw, ch_busy}, exp);
            end
            adv();
        end
        flush = 1'b0;
        ch_bgn = '0;
    endtask

    // ch2 event: bgn at 0, second bgn at 2 ignored, end at 4; stray end on idle ch3 at 1.
    task automatic test_bgn_while_busy();
        logic [5:0] exp;
        for (int c = 0; c < 7; c++) begin
            ch_bgn = (c == 0 || c == 2) ? 4'b0100 : 4'b0000;
            ch_end = (c == 4) ? 4'b0100 : ((c == 1) ? 4'b1000 : 4'b0000);
            exp = {(c <= 3) ? 1'b1 : 1'b0,
                   (c >= 1 && c <= 3) ? 1'b1 : 1'b0,
                   (c >= 1 && c <= 4) ? 4'b0100 : 4'b0000};
            @(negedge clk);
            checks++;
            if ({stall_ifu, stall_reg_mw, ch_busy} !== exp) begin
                errors++;
                $display("FAIL busy_rebgn c%0d: got %b, need %b", c, {stall_ifu, stall_reg_mw, ch_busy}, exp);
            end
            adv();
        end
        ch_bgn = '0;
        ch_end = '0;
    endtask

    // Asynchronous reset at cycle 3 of a ch0 stall, then a normal event sequence.
    task automatic test_async_reset();
        ch_bgn = 4'b0001;
        adv();
        ch_bgn = 4'b0000;
        adv();
        adv();
        #2;
        checks++;
        if ({stall_ifu, stall_reg_mw, ch_busy} !== {1'b1, 1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL pre_areset: got %b, need 110001", {stall_ifu, stall_reg_mw, ch_busy});
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({stall_ifu, stall_reg_mw, ch_busy, tmo_err} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset: got %b, need 0", {stall_ifu, stall_reg_mw, ch_busy, tmo_err});
        end
        @(negedge clk);
        resetn = 1'b1;
        adv();
        test_event();
    endtask

    initial begin
        test_reset();
        test_event();
        test_fixed(1'b0);
        test_fixed(1'b1);
        test_bgn_end_same();
        test_flush();
        test_bgn_while_busy();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
